merger_select_1: RTL

- Upstream input-select stage of a 1-merger: one element per cycle, feeding the 2-element compare-exchange network directly downstream.
- Watches the heads of two show-ahead input FIFOs (streams A and B), each carrying sorted runs. Picks the smaller-key head, dequeues it, and presents it registered to the network with a stall flag and a source-switch flag.
- Handles end-of-run terminal tuples so that runs stay aligned between the two streams.

---
 rtl/merger_pkg.sv | 10 +
 rtl/key_cmp_2.sv | 18 +
 rtl/merger_select_1.sv | 103 ++++++++++
 3 files changed

// File: rtl/merger_pkg.sv
// merger_pkg: shared widths, state encoding and terminal-key test for the merger select stage
package merger_pkg;
    localparam int DATA_WIDTH = 128;
    localparam int KEY_WIDTH = 80;
    typedef enum logic [1:0] {MERGE, DRAIN_A, DRAIN_B, TERM} sel_state_e;
    typedef enum logic {SRC_A, SRC_B} src_e;
    function automatic logic is_term(input logic [KEY_WIDTH-1:0] key);
        return key == '0;
    endfunction
endpackage

// File: rtl/key_cmp_2.sv
// key_cmp_2: unsigned key compare and terminal detect for the two FIFO heads
import merger_pkg::*;
module key_cmp_2 #(
    parameter int DATA_WIDTH = merger_pkg::DATA_WIDTH,
    parameter int KEY_WIDTH = merger_pkg::KEY_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  a_le_b_o,
    output logic                  a_term_o,
    output logic                  b_term_o
);
    always_comb begin
        a_le_b_o = a_data_i[KEY_WIDTH-1:0] <= b_data_i[KEY_WIDTH-1:0];
        a_term_o = is_term(a_data_i[KEY_WIDTH-1:0]);
        b_term_o = is_term(b_data_i[KEY_WIDTH-1:0]);
    end
endmodule

// File: rtl/merger_select_1.sv
// merger_select_1: picks the smaller-key head of two sorted FIFO streams, one element per cycle,
// keeping run boundaries aligned by consuming both terminal tuples together.
import merger_pkg::*;
module merger_select_1 #(
    parameter int DATA_WIDTH = merger_pkg::DATA_WIDTH,
    parameter int KEY_WIDTH = merger_pkg::KEY_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic                  i_a_empty,
    output logic                  o_a_deq,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    input  logic                  i_b_empty,
    output logic                  o_b_deq,
    input  logic                  i_stall,
    output logic [DATA_WIDTH-1:0] o_elem,
    output logic                  o_stall,
    output logic                  o_switch_output
);
    sel_state_e state_q, state_d;
    src_e last_src_q, last_src_d;
    logic [DATA_WIDTH-1:0] elem_q, elem_d;
    logic stall_q, switch_q, switch_d;
    logic a_le_b, a_term, b_term, need, fire, emit;
    key_cmp_2 #(.DATA_WIDTH(DATA_WIDTH), .KEY_WIDTH(KEY_WIDTH)) u_cmp (
        .a_data_i(i_a_data),
        .b_data_i(i_b_data),
        .a_le_b_o(a_le_b),
        .a_term_o(a_term),
        .b_term_o(b_term)
    );
    always_comb begin
        need = (state_q == DRAIN_A) ? ~i_a_empty :
               (state_q == DRAIN_B) ? ~i_b_empty : ~i_a_empty & ~i_b_empty;
        fire = i_rst_n & ~i_stall & need;
        state_d = state_q;
        last_src_d = last_src_q;
        emit = 1'b0;
        o_a_deq = 1'b0;
        o_b_deq = 1'b0;
        if (fire) begin
            case (state_q)
                MERGE: begin
                    if (a_term && b_term) begin
                        state_d = TERM;
                    end else if (a_term) begin
                        state_d = DRAIN_B;
                        last_src_d = SRC_B;
                    end else if (b_term) begin
                        state_d = DRAIN_A;
                        last_src_d = SRC_A;
                    end else begin
                        emit = 1'b1;
                        o_a_deq = a_le_b;
                        o_b_deq = ~a_le_b;
                        last_src_d = a_le_b ? SRC_A : SRC_B;
                    end
                end
                DRAIN_A: begin
                    state_d = a_term ? TERM : DRAIN_A;
                    emit = ~a_term;
                    o_a_deq = ~a_term;
                    last_src_d = SRC_A;
                end
                DRAIN_B: begin
                    state_d = b_term ? TERM : DRAIN_B;
                    emit = ~b_term;
                    o_b_deq = ~b_term;
                    last_src_d = SRC_B;
                end
                TERM: begin
                    // both terminals leave together; A's copy represents the run end
                    state_d = MERGE;
                    emit = 1'b1;
                    o_a_deq = 1'b1;
                    o_b_deq = 1'b1;
                    last_src_d = SRC_A;
                end
            endcase
        end
        elem_d = emit ? (o_a_deq ? i_a_data : i_b_data) : elem_q;
        switch_d = emit & (last_src_d != last_src_q);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= MERGE;
            last_src_q <= SRC_A;
            elem_q <= '0;
            stall_q <= 1'b1;
            switch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_src_q <= last_src_d;
            elem_q <= elem_d;
            stall_q <= ~emit;
            switch_q <= switch_d;
        end
    end
    assign o_elem = elem_q;
    assign o_stall = stall_q;
    assign o_switch_output = switch_q;
endmodule
